ram_access_scheduler: RTL and testbench
=======================================

// Module: ram_access_scheduler
// PURPOSE
//   Shares one single-port RAM (1-cycle read latency) between two requesters.
//   Each requester has its own start/ready/done handshake and a one-entry command buffer.
//   Buffered commands are served round-robin: one RAM access at a time, each with a fixed service time.
//   Sits between client FSMs and the read_write_ram storage.
// PARAMETERS
//   ADDR_WIDTH  4   RAM address width
//   DATA_WIDTH  16  RAM data width
// PORTS
//   clk                  in   1           single clock; all state updates on rising edge
//   rst                  in   1           synchronous, active-high reset
//   req0_start/req1_start  in   1        command strobe, sampled only when matching ready=1
//   req0_we/req1_we        in   1        1=write, 0=read; sampled with start
//   req0_addr/req1_addr    in   ADDR_WIDTH   sampled with start
//   req0_wdata/req1_wdata  in   DATA_WIDTH   sampled with start
//   req0_ready/req1_ready  out  1        requester may issue start
//   req0_done/req1_done    out  1        1-cycle completion pulse
//   req0_rdata/req1_rdata  out  DATA_WIDTH   read result, registered
//   ram_en               out  1           RAM access strobe
//   ram_we               out  1           RAM write enable (only meaningful with ram_en)
//   ram_addr             out  ADDR_WIDTH  RAM address
//   ram_wdata            out  DATA_WIDTH  RAM write data
//   ram_rdata            in   DATA_WIDTH  valid the cycle after ram_en & !ram_we
// BEHAVIOUR
// - Reset (rst=1 at an edge) gives, on the next cycle:
//   - state=IDLE, pending0/1=0, last_grant=1 (req0 wins first tie);
//   - all done=0, ram_en=0, ram_we=0, rdata=0, ram_addr/ram_wdata=0, both ready=1.
//   - Reset mid-operation aborts the access: no done pulse, and both buffers are dropped.
// - FSM states: IDLE, ISSUE, WAIT, DONE. "Free" means state IDLE or DONE.
// - Candidate_i = pending_i | (start_i & ready_i).
// - Edge while free:
//   - If any candidate exists, the winner goes to ISSUE and becomes owner; otherwise go to IDLE.
//   - Winner is the sole candidate; on a tie, the requester != last_grant.
//   - last_grant <= winner.
//   - The winner's command comes from its buffer if pending, else from its inputs.
//   - A losing start is captured into its buffer (pending_i <= 1).
// - ISSUE -> WAIT -> DONE: unconditional, one cycle each.
// - RAM outputs:
//   - ram_en=1 only in ISSUE, with ram_we/ram_addr/ram_wdata = owner command.
//   - ram_addr and ram_wdata hold their values outside ISSUE.
// - Read data capture:
//   - In WAIT, for a read, ram_rdata is registered into the owner's rdata at the WAIT->DONE edge.
//   - rdata holds until that requester's next read completes; writes leave rdata unchanged.
// - DONE: done_owner=1 for exactly this cycle.
// - ready_i = !pending_i & !(state in {ISSUE,WAIT} & owner==i).
//   - Ready is therefore 1 in the owner's DONE cycle, and a back-to-back start there is legal.
// - Latency: start accepted at edge E with scheduler free gives:
//   - ISSUE in cycle E..E+1;
//   - ready_i=0 after E and after E+1;
//   - done_i=1 and ready_i=1 after E+2.
//   - If the request is buffered behind the other owner, it waits for the next free edge.
// - Simultaneous events:
//   - A start while ready=0 is ignored (no capture, no error).
//   - Owner's new start in DONE, together with the other's pending request: the other wins (round-robin).
//   - Max wait for any accepted request is one full foreign service (3 cycles) plus its own.
// TESTING
// Bench: RAM model with 1-cycle registered read.
//   1. Hold rst=1 for 1 edge -> both ready=1, both done=0, ram_en=0, rdata=0.
//   2. req0 write addr=3 data=16'hBEEF at edge E:
//      - ram_en=1, ram_we=1, ram_addr=3 after E;
//      - ready0=0 after E and after E+1;
//      - done0=1 and ready0=1 after E+2.
//   3. Then req1 read addr=3 -> done1 pulse 2 edges after accept, req1_rdata=16'hBEEF; req0_rdata unchanged.
//   4. Both start on the same edge after reset (req0 wr addr 1=0x0011; req1 rd addr 1):
//      - req0 served first: done0 at E+2;
//      - req1 ready=0 until it is served; done1 at E+5, rdata1=0x0011.
//   5. req0 restarts in every DONE cycle; req1 starts once -> req1 is served next, then req0 again.
//      No starvation; done pulses alternate.
//   6. rst=1 in WAIT of a req0 read with req1 pending:
//      - no done pulse follows;
//      - after reset both ready=1, no further ram_en, and rdata stays 0.

Source files
------------

// File: rtl/ram_access_scheduler.sv
// Round-robin scheduler sharing one single-port RAM (1-cycle read latency)
// between two requesters, each with a start/ready/done handshake and a one-entry buffer.
module ram_access_scheduler #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_start,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_start,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic                  req0_done,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    logic [1:0]            r_pending;
    logic [1:0]            r_buf_we;
    logic [ADDR_WIDTH-1:0] r_buf_addr  [2];
    logic [DATA_WIDTH-1:0] r_buf_wdata [2];
    logic                  r_owner;
    logic                  r_last_grant;
    logic                  r_cmd_we;
    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic [1:0]            r_done;
    logic [DATA_WIDTH-1:0] r_rdata [2];

    logic [1:0]            w_start;
    logic [1:0]            w_in_we;
    logic [ADDR_WIDTH-1:0] w_in_addr  [2];
    logic [DATA_WIDTH-1:0] w_in_wdata [2];
    logic                  w_busy;
    logic                  w_free;
    logic [1:0]            w_ready;
    logic [1:0]            w_acc;
    logic [1:0]            w_cand;
    logic [1:0]            w_capture;
    logic                  w_win;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    always_comb begin
        w_start       = {req1_start, req0_start};
        w_in_we       = {req1_we, req0_we};
        w_in_addr[0]  = req0_addr;
        w_in_addr[1]  = req1_addr;
        w_in_wdata[0] = req0_wdata;
        w_in_wdata[1] = req1_wdata;

        w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT);
        w_free     = (r_state == S_IDLE) || (r_state == S_DONE);
        w_ready[0] = !r_pending[0] && !(w_busy && (r_owner == 1'b0));
        w_ready[1] = !r_pending[1] && !(w_busy && (r_owner == 1'b1));
        w_acc      = w_start & w_ready;
        w_cand     = r_pending | w_acc;

        // Tie goes to the requester that did not win last time.
        w_win = (&w_cand) ? ~r_last_grant : w_cand[1];

        // A start that is not granted this edge is parked in its buffer.
        w_capture[0] = w_acc[0] && !(w_free && (w_win == 1'b0));
        w_capture[1] = w_acc[1] && !(w_free && (w_win == 1'b1));

        w_sel_we    = r_pending[w_win] ? r_buf_we[w_win]    : w_in_we[w_win];
        w_sel_addr  = r_pending[w_win] ? r_buf_addr[w_win]  : w_in_addr[w_win];
        w_sel_wdata = r_pending[w_win] ? r_buf_wdata[w_win] : w_in_wdata[w_win];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_buf_we     <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cmd_we     <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_done       <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_buf_addr[i]  <= '0;
                r_buf_wdata[i] <= '0;
                r_rdata[i]     <= '0;
            end
        end else begin
            r_done   <= '0;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;

            for (int unsigned i = 0; i < 2; i++) begin
                if (w_capture[i]) begin
                    r_pending[i]   <= 1'b1;
                    r_buf_we[i]    <= w_in_we[i];
                    r_buf_addr[i]  <= w_in_addr[i];
                    r_buf_wdata[i] <= w_in_wdata[i];
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (|w_cand) begin
                        r_state            <= S_ISSUE;
                        r_owner            <= w_win;
                        r_last_grant       <= w_win;
                        r_pending[w_win]   <= 1'b0;
                        r_cmd_we           <= w_sel_we;
                        r_ram_en           <= 1'b1;
                        r_ram_we           <= w_sel_we;
                        r_ram_addr         <= w_sel_addr;
                        r_ram_wdata        <= w_sel_wdata;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    r_state          <= S_DONE;
                    r_done[r_owner]  <= 1'b1;
                    if (!r_cmd_we)
                        r_rdata[r_owner] <= ram_rdata;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign req0_done  = r_done[0];
    assign req1_done  = r_done[1];
    assign req0_rdata = r_rdata[0];
    assign req1_rdata = r_rdata[1];
    assign ram_en     = r_ram_en;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_ram_access_scheduler.sv
// Directed bench for ram_access_scheduler: registered-read RAM model plus a
// scoreboard of expected completions (requester id and rdata) in service order.
module tb_ram_access_scheduler;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_start = 1'b0, req1_start = 1'b0;
    logic          req0_we = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_ready, req1_ready, req0_done, req1_done;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] ram_mem [16];

    typedef struct {
        int unsigned   id;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_mem [16];
    logic [DW-1:0] last_rd   [2];
    int            checks = 0;
    int            errors = 0;

    ram_access_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_start(req0_start), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_start(req1_start), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_done(req0_done), .req1_done(req1_done),
        .req0_rdata(req0_rdata), .req1_rdata(req1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 16; i++) ram_mem[i] = '0;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int unsigned id, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
        exp_t e;
        if (we) model_mem[addr] = wdata;
        else    last_rd[id] = model_mem[addr];
        e.id    = id;
        e.rdata = last_rd[id];
        sb.push_back(e);
    endtask

    // Advance one edge, then sample and retire any completion against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if ((i == 0) ? req0_done : req1_done) begin
                chk("done_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_order", i, e.id);
                    chk("done_rdata", (i == 0) ? req0_rdata : req1_rdata, e.rdata);
                end
            end
        end
    endtask

    task automatic wait_done(input int unsigned id, input int budget);
        logic seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            tick();
            seen = (id == 0) ? req0_done : req1_done;
        end
        chk("wait_done", seen, 1);
    endtask

    task automatic start(input int unsigned id, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        if (id == 0) begin
            req0_start = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_start = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    task automatic release_starts();
        req0_start = 1'b0;
        req1_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;

        // 1. reset state
        do_reset();
        chk("rst_ready0", req0_ready, 1);
        chk("rst_ready1", req1_ready, 1);
        chk("rst_done0", req0_done, 0);
        chk("rst_done1", req1_done, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_rdata0", req0_rdata, 0);
        chk("rst_rdata1", req1_rdata, 0);

        // 2. req0 write addr 3 = BEEF, latency profile
        start(0, 1'b1, 4'd3, 16'hBEEF);
        push_exp(0, 1'b1, 4'd3, 16'hBEEF);
        tick();
        release_starts();
        chk("t2_ram_en", ram_en, 1);
        chk("t2_ram_we", ram_we, 1);
        chk("t2_ram_addr", ram_addr, 3);
        chk("t2_ram_wdata", ram_wdata, 16'hBEEF);
        chk("t2_ready0_e", req0_ready, 0);
        chk("t2_ready1_e", req1_ready, 1);
        tick();
        chk("t2_ready0_e1", req0_ready, 0);
        chk("t2_ram_en_e1", ram_en, 0);
        chk("t2_addr_hold", ram_addr, 3);
        tick();
        chk("t2_done0", req0_done, 1);
        chk("t2_ready0_e2", req0_ready, 1);

        // 3. req1 reads addr 3 back, started in req0's DONE cycle
        start(1, 1'b0, 4'd3, '0);
        push_exp(1, 1'b0, 4'd3, '0);
        tick();
        release_starts();
        chk("t3_ram_en", ram_en, 1);
        chk("t3_ram_we", ram_we, 0);
        chk("t3_ready1", req1_ready, 0);
        tick();
        tick();
        chk("t3_done1", req1_done, 1);
        chk("t3_rdata1", req1_rdata, 16'hBEEF);
        chk("t3_rdata0", req0_rdata, 0);

        // 4. simultaneous starts after reset: req0 first, req1 buffered
        do_reset();
        start(0, 1'b1, 4'd1, 16'h0011);
        start(1, 1'b0, 4'd1, '0);
        push_exp(0, 1'b1, 4'd1, 16'h0011);
        push_exp(1, 1'b0, 4'd1, '0);
        tick();
        release_starts();
        chk("t4_ready1_e", req1_ready, 0);
        tick();
        tick();
        chk("t4_done0", req0_done, 1);
        chk("t4_ready1_e2", req1_ready, 0);
        tick();
        chk("t4_ready1_e3", req1_ready, 0);
        chk("t4_ram_en_e3", ram_en, 1);
        tick();
        tick();
        chk("t4_done1", req1_done, 1);
        chk("t4_rdata1", req1_rdata, 16'h0011);
        chk("t4_ready1_e5", req1_ready, 1);

        // 5. req0 restarts in its DONE cycles; req1's single request is not starved
        tick();
        start(0, 1'b1, 4'd5, 16'h0055);
        push_exp(0, 1'b1, 4'd5, 16'h0055);
        tick();
        release_starts();
        start(1, 1'b0, 4'd5, '0);
        push_exp(1, 1'b0, 4'd5, '0);
        tick();
        release_starts();
        tick();
        chk("t5_done0_a", req0_done, 1);
        start(0, 1'b1, 4'd6, 16'h0066);
        push_exp(0, 1'b1, 4'd6, 16'h0066);
        tick();
        release_starts();
        chk("t5_req1_granted", ram_we, 0);
        chk("t5_ready0_buffered", req0_ready, 0);
        wait_done(1, 8);
        wait_done(0, 8);
        start(0, 1'b1, 4'd7, 16'h0077);
        push_exp(0, 1'b1, 4'd7, 16'h0077);
        tick();
        release_starts();
        wait_done(0, 8);
        chk("t5_sb_empty", sb.size(), 0);

        // 6. reset in WAIT of req0 read with req1 pending: everything dropped
        tick();
        start(0, 1'b0, 4'd5, '0);
        tick();
        release_starts();
        start(1, 1'b0, 4'd6, '0);
        tick();
        release_starts();
        chk("t6_pending1", req1_ready, 0);
        do_reset();
        chk("t6_ready0", req0_ready, 1);
        chk("t6_ready1", req1_ready, 1);
        chk("t6_done0", req0_done, 0);
        chk("t6_ram_en", ram_en, 0);
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("t6_no_ram_en", ram_en, 0);
            chk("t6_rdata0", req0_rdata, 0);
        end
        chk("t6_rdata1", req1_rdata, 0);
        chk("t6_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
